// File: rtl/n_bit_register_set_pkg.sv
// Shared constants, operation encoding and decode helpers for the
// eight-entry general-purpose register bank.
package n_bit_register_set_pkg;

  localparam int unsigned REG_COUNT = 8;
  localparam int unsigned ADDR_W    = 3;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_e;

  // Port operation implied by enable and access type (reset handled separately).
  function automatic op_e classify_op(input logic enable, input logic rw);
    op_e op;
    op = OP_IDLE;
    if (enable) begin
      op = (rw == RW_WRITE) ? OP_WRITE : OP_READ;
    end
    return op;
  endfunction

  // One-hot register select for a fully decoded address.
  function automatic logic [REG_COUNT-1:0] decode_one_hot(input logic [ADDR_W-1:0] addr);
    logic [REG_COUNT-1:0] sel;
    sel = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      sel[i] = (addr == ADDR_W'(i));
    end
    return sel;
  endfunction

endpackage

// File: rtl/n_bit_register_set_nbit_register.sv
// n-bit storage register with synchronous active-high reset and load enable.
module nbit_register #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/n_bit_register_set.sv
// Eight-entry register bank with one shared read/write port and a
// registered read result.
module n_bit_register_set
  import n_bit_register_set_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Enable,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Address,
  input  logic [n-1:0]      Data_in,
  output logic [n-1:0]      Data_out
);

  op_e                  op;
  logic [REG_COUNT-1:0] addr_sel;
  logic [REG_COUNT-1:0] wr_en;
  logic [n-1:0]         regs [REG_COUNT];
  logic [n-1:0]         rd_data;

  // Address decode; write strobes only on an enabled write.
  always_comb begin
    op       = classify_op(Enable, RW);
    addr_sel = decode_one_hot(Address);
    wr_en    = '0;
    if (op == OP_WRITE) begin
      wr_en = addr_sel;
    end
  end

  for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
    nbit_register #(
      .W(n)
    ) u_reg (
      .clk (Clk),
      .rst (nReset),
      .load(wr_en[i]),
      .d   (Data_in),
      .q   (regs[i])
    );
  end

  // Read mux sees pre-edge contents, so a read never observes a same-edge write.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < REG_COUNT; i++) begin
      if (addr_sel[i]) begin
        rd_data = regs[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (nReset) begin
      Data_out <= '0;
    end else if (op == OP_READ) begin
      Data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_n_bit_register_set.sv
// Self-checking bench: directed vector table, randomized traffic against a
// behavioural model, and width sweeps at n=1 and n=16.
module tb_n_bit_register_set;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // n = 8 instance
  logic       rst = 1'b1, en = 1'b0, rw = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] din = '0, dout;

  // n = 16 instance
  logic        rst16 = 1'b1, en16 = 1'b0, rw16 = 1'b0;
  logic [2:0]  addr16 = '0;
  logic [15:0] din16 = '0, dout16;

  // n = 1 instance
  logic       rst1 = 1'b1, en1 = 1'b0, rw1 = 1'b0;
  logic [2:0] addr1 = '0;
  logic [0:0] din1 = '0, dout1;

  n_bit_register_set #(.n(8)) dut8 (
    .Clk(clk), .nReset(rst), .Enable(en), .RW(rw),
    .Address(addr), .Data_in(din), .Data_out(dout)
  );

  n_bit_register_set #(.n(16)) dut16 (
    .Clk(clk), .nReset(rst16), .Enable(en16), .RW(rw16),
    .Address(addr16), .Data_in(din16), .Data_out(dout16)
  );

  n_bit_register_set #(.n(1)) dut1 (
    .Clk(clk), .nReset(rst1), .Enable(en1), .RW(rw1),
    .Address(addr1), .Data_in(din1), .Data_out(dout1)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  // Behavioural model of the n=8 bank.
  logic [7:0] mem [8];
  logic [7:0] model_out;

  task automatic model_step(input logic r, input logic e, input logic w,
                            input logic [2:0] a, input logic [7:0] d);
    if (r) begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      model_out = 8'h00;
    end else if (e && w) begin
      mem[a] = d;
    end else if (e) begin
      model_out = mem[a];
    end
  endtask

  // Apply one operation to the n=8 instance and sample after the edge.
  task automatic cyc(input logic r, input logic e, input logic w,
                     input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    rst = r; en = e; rw = w; addr = a; din = d;
    @(posedge clk);
    #1;
    model_step(r, e, w, a, d);
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic       w;
    logic [2:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic e, input logic w,
                              input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp);
    vec_t v;
    v.r = r; v.e = e; v.w = w; v.a = a; v.d = d; v.exp = exp;
    return v;
  endfunction

  logic [7:0] wvals [8];

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'hxx;
    model_out = 8'hxx;
    wvals = '{8'h55, 8'h0F, 8'h33, 8'h1D, 8'hAA, 8'hCC, 8'hE2, 8'hFF};

    // Reset held two cycles while a write is requested.
    vecs.push_back(mk(1, 1, 1, 3'd3, 8'hFF, 8'h00));
    vecs.push_back(mk(1, 1, 1, 3'd3, 8'hFF, 8'h00));
    vecs.push_back(mk(0, 1, 0, 3'd3, 8'h00, 8'h00));
    // Write all (Data_out holds), then read all.
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 1, 3'(i), wvals[i], 8'h00));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 0, 3'(i), 8'h00, wvals[i]));
    // Enable gating.
    vecs.push_back(mk(0, 0, 1, 3'd2, 8'h99, 8'hFF));
    vecs.push_back(mk(0, 0, 0, 3'd5, 8'h00, 8'hFF));
    vecs.push_back(mk(0, 1, 0, 3'd2, 8'h00, 8'h33));
    // Read-after-write.
    vecs.push_back(mk(0, 1, 1, 3'd6, 8'hA5, 8'h33));
    vecs.push_back(mk(0, 1, 0, 3'd6, 8'h00, 8'hA5));
    vecs.push_back(mk(0, 1, 0, 3'd7, 8'h00, 8'hFF));
    // Reset during a write, then normal operation resumes.
    vecs.push_back(mk(1, 1, 1, 3'd1, 8'h3C, 8'h00));
    vecs.push_back(mk(0, 1, 0, 3'd1, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 0, 3'd7, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1, 1, 3'd1, 8'h3C, 8'h00));
    vecs.push_back(mk(0, 1, 0, 3'd1, 8'h00, 8'h3C));

    foreach (vecs[i]) begin
      cyc(vecs[i].r, vecs[i].e, vecs[i].w, vecs[i].a, vecs[i].d);
      check($sformatf("vec%0d", i), 16'(dout), 16'(vecs[i].exp));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, e, w;
      logic [2:0] a;
      logic [7:0] d;
      r = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 3) != 0);
      w = 1'($urandom);
      a = 3'($urandom);
      d = 8'($urandom);
      cyc(r, e, w, a, d);
      check($sformatf("rand%0d", i), 16'(dout), 16'(model_out));
    end

    // Drain: read every register and compare against the model contents.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 3'(i), 8'h00);
      check($sformatf("drain%0d", i), 16'(dout), 16'(model_out));
    end

    // n=16 and n=1 sweeps.
    @(negedge clk);
    rst16 = 1'b1; rst1 = 1'b1;
    @(negedge clk);
    check("w16_reset", dout16, 16'h0000);
    check("w1_reset", 16'(dout1), 16'h0000);
    rst16 = 1'b0; en16 = 1'b1; rw16 = 1'b1; addr16 = 3'd4; din16 = 16'hBEEF;
    rst1 = 1'b0; en1 = 1'b1; rw1 = 1'b1; addr1 = 3'd7; din1 = 1'b1;
    @(negedge clk);
    check("w16_hold", dout16, 16'h0000);
    addr16 = 3'd0; din16 = 16'h4110;
    addr1 = 3'd0; din1 = 1'b0;
    @(negedge clk);
    rw16 = 1'b0; addr16 = 3'd4;
    rw1 = 1'b0; addr1 = 3'd7;
    @(negedge clk);
    check("w16_rd4", dout16, 16'hBEEF);
    check("w1_rd7", 16'(dout1), 16'h0001);
    addr16 = 3'd0; addr1 = 3'd0;
    @(negedge clk);
    check("w16_rd0", dout16, 16'h4110);
    check("w1_rd0", 16'(dout1), 16'h0000);
    en16 = 1'b0; en1 = 1'b0; addr16 = 3'd4; addr1 = 3'd7;
    @(negedge clk);
    check("w16_idle", dout16, 16'h4110);
    check("w1_idle", 16'(dout1), 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/n_bit_register_set.md
# n_bit_register_set

Eight-entry register file of n-bit words with a single shared read/write port, addressed by a 3-bit address. It serves as the general-purpose register bank of the microprocessor datapath. Writes and reads are synchronous to one clock. The read result is held on a registered output.

## Interface
- n, default 8, word width in bits (n ≥ 1)
- Clk  input  1  system clock; all state updates on rising edge
- nReset  input  1  synchronous, active-high reset (despite the name: 1 = reset)
- Enable  input  1  port enable; 0 = no operation
- RW  input  1  access type: 1 = write, 0 = read
- Address  input  3  register select, 0..7
- Data_in  input  n  write data
- Data_out  output  n  registered read data

## Operation
- State: eight n-bit registers R0..R7, plus the n-bit output register Data_out.
- Priority at each rising Clk edge: reset first, then write, then read, then hold.
- Reset (nReset=1):
  - R0..R7 = 0 and Data_out = 0.
  - Overrides Enable/RW; any concurrent write is discarded.
- Write (nReset=0, Enable=1, RW=1):
  - R[Address] = Data_in.
  - Other registers unchanged.
  - Data_out holds its previous value.
- Read (nReset=0, Enable=1, RW=0):
  - Data_out = R[Address].
  - Registers unchanged.
- Idle (nReset=0, Enable=0): all state holds, regardless of RW, Address and Data_in.
- Address decodes fully; all eight values are valid, with no out-of-range case.
- Widths are exact n bits, with no truncation or extension. Data_in and Data_out are the same width as the registers.

## Timing
- Write latency: R[Address] updates at the sampling edge. A read issued on the next cycle returns the new value.
- Read latency: one cycle. Data_out reflects R[Address] after the edge at which the read is sampled.
- Read data is the register contents before that edge's update. A single port means no same-cycle write/read conflict.
- Back-to-back operations are allowed every cycle with no handshake and no stall.
- Reset mid-operation: the reset edge wins. Content written before reset is lost, and Data_out returns 0 on the reset edge.
- After reset release, the first operation is accepted on the next edge.
- Data_out changes only on a rising Clk edge: glitch-free and never combinational from the inputs.

## Structure
- Shared package holds:
  - constant REG_COUNT = 8
  - constant ADDR_W = 3
  - constants for the RW encoding: RW_WRITE = 1, RW_READ = 0
- One natural sub-module, nbit_register:
  - n-bit register with synchronous active-high reset and load enable.
  - Instantiated eight times.
  - Write-enable decode: one-hot from Address, gated by Enable & RW.
- Top level contains:
  - the address decoder
  - an 8:1 n-bit read mux
  - the Data_out register, loaded on Enable & ~RW

## Test plan
- Reset: hold nReset=1 for 2 cycles with Enable=1, RW=1, Data_in=8'hFF, Address=3 -> all registers 0, Data_out=0; a subsequent read of R3 returns 8'h00.
- Write all then read all: write 8'h55, 0F, 33, 1D, AA, CC, E2, FF to addresses 0..7 on consecutive cycles -> Data_out unchanged during the writes; reads of 0..7 return the same values, each one cycle after issue.
- Enable gating: Enable=0 with RW=1, Address=2, Data_in=8'h99 -> R2 unchanged (8'h33). Enable=0 with RW=0 -> Data_out holds its last value.
- Read-after-write: write 8'hA5 to R6, then read R6 on the next cycle -> Data_out=8'hA5 one cycle later; R7 still 8'hFF.
- Reset mid-sequence: assert nReset during a write of 8'h3C to R1 -> R1=0 and Data_out=0 after that edge; normal writes resume after release.
- Parameter sweep: n=1 and n=16 -> same behaviour with full-width patterns (16'hBEEF at address 4 reads back exactly).
